jtframe_vtimer: RTL and testbench
=================================

JTFRAME_VTIMER -- requirements
Module: jtframe_vtimer

Interface
REQ-001 SHALL have parameter HCNT_START, default 9'h000, first horizontal count value.
REQ-002 SHALL have parameter HCNT_END, default 9'h17F, last horizontal count value.
REQ-003 SHALL have parameter HB_START, default 9'h13F, H value where horizontal blank begins.
REQ-004 SHALL have parameter HB_END, default 9'h17F, H value where horizontal blank ends.
REQ-005 SHALL have parameter HS_START, default 9'h150, H value where HS asserts.
REQ-006 SHALL have parameter HS_END, default HS_START+9'd27, H value where HS deasserts.
REQ-007 SHALL have parameter H_VNEXT, default HB_START, H value at which the vertical counter advances.
REQ-008 SHALL have parameter H_VB, default H_VNEXT, H value at which LVBL updates.
REQ-009 SHALL have parameter H_VS, default HS_START, H value at which VS updates.
REQ-010 SHALL have parameter HINIT, default H_VNEXT, H value that pulses Hinit.
REQ-011 SHALL have parameter V_START, default 9'h0F8, first vertical count value.
REQ-012 SHALL have parameter VCNT_END, default 9'h1FF, last vertical count value.
REQ-013 SHALL have parameter VB_START, default 9'h1EF, line where vertical blank begins.
REQ-014 SHALL have parameter VB_END, default 9'h10F, line where vertical blank ends.
REQ-015 SHALL have parameter VS_START, default 9'h1F0, line where VS asserts.
REQ-016 SHALL have parameter VS_END, default VS_START+9'd3, line where VS deasserts.
REQ-017 SHALL have one clock and an asynchronous active-high reset: ports clk and rst.
REQ-018 Ports: clk in 1 system clock; rst in 1 async active-high reset; pxl_cen in 1 pixel clock enable; vdump out 9 current line; vrender out 9 next line; vrender1 out 9 line after next; H out 9 horizontal count; Hinit out 1 line-start pulse; Vinit out 1 frame-start pulse; LHBL out 1 active-low hblank; LVBL out 1 active-low vblank; HS out 1 hsync (active high); VS out 1 vsync (active high).

Function
REQ-019 All state SHALL update only on rising clk with pxl_cen=1; pxl_cen=0 holds everything.
REQ-020 H SHALL count +1 per pxl_cen, HCNT_END -> HCNT_START wrap.
REQ-021 Hinit SHALL be 1 for the one pixel where H==HINIT, else 0.
REQ-022 When H==H_VNEXT: vdump <= vrender, vrender <= vrender1, vrender1 <= next(vrender1), next(v) = (v==VCNT_END) ? V_START : v+1; thus vdump spans V_START..VCNT_END and vrender/vrender1 lead by 1/2 lines modulo the range.
REQ-023 LHBL SHALL go 0 on the pixel H reaches HB_START and 1 on the pixel H reaches HB_END (registered, one pxl_cen after the compare).
REQ-024 HS SHALL go 1 when H==HS_START, 0 when H==HS_END (registered).
REQ-025 At H==H_VB: LVBL <= 0 if vdump==VB_START, LVBL <= 1 if vdump==VB_END, else hold.
REQ-026 At H==H_VS: VS <= 1 if vdump==VS_START, VS <= 0 if vdump==VS_END, else hold.
REQ-027 Vinit SHALL be 1 for the one pixel where H==H_VB and vdump==VB_END.
REQ-028 Equal start/end parameters: end (deassert) comparison wins; blank spanning the wrap SHALL be supported.

Reset
REQ-029 rst=1 SHALL immediately force H=HCNT_START, vdump=V_START, vrender=next(V_START), vrender1=next(next(V_START)), LHBL=0, LVBL=0, HS=0, VS=0, Hinit=0, Vinit=0; counting resumes on the first pxl_cen after rst falls; rst mid-frame restarts the frame.

Verification
Bench params: HCNT 020..19F, HB 19F->05F, HS 033->04D, V_START 0F8, VCNT_END 1FF, VB 1F0->110, VS_START 0FA; clk 12 MHz, pxl_cen every other clk.
REQ-030 Line length: successive Hinit pulses 384 pixels (64 us) apart; H wraps 19F->020.
REQ-031 Horizontal timing: LHBL low 64 pixels (10.67 us), HS high 26 pixels (4.33 us) per line.
REQ-032 Frame: vdump 0F8..1FF then 0F8, 264 lines, Vinit period 16.896 ms (59.18 Hz); vrender==vdump+1, vrender1==vdump+2 except 1FF->0F8 wrap.
REQ-033 Vertical timing: LVBL low 40 lines (2.56 ms) from line 1F0 to 110; VS high 3 lines from 0FA to 0FD.
REQ-034 Reset: assert rst mid-frame -> outputs at REQ-029 values asynchronously; with pxl_cen held 0, counters frozen.

Source files
------------

// File: rtl/jtframe_vtimer.sv
// -----------------------------------------------------------------------------
// jtframe_vtimer
//   Video timing generator. A horizontal pixel counter H runs from HCNT_START
//   to HCNT_END. Once per line, at H == H_VNEXT, a three-deep line pipeline
//   advances:
//     - vdump holds the line being displayed.
//     - vrender holds the next line.
//     - vrender1 holds the line after that.
//   Blanking, sync and frame/line start pulses are decoded from H and vdump.
//   All state advances only on clk edges where pxl_cen is high.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   pxl_cen  in   pixel clock enable
//   vdump    out  [8:0] current line
//   vrender  out  [8:0] next line
//   vrender1 out  [8:0] line after next
//   H        out  [8:0] horizontal count
//   Hinit    out  high for the pixel where H == HINIT
//   Vinit    out  high for the pixel where H == H_VB and vdump == VB_END
//   LHBL     out  horizontal blank, active low
//   LVBL     out  vertical blank, active low
//   HS       out  horizontal sync, active high
//   VS       out  vertical sync, active high
// -----------------------------------------------------------------------------
module jtframe_vtimer #(
    parameter logic [8:0] HCNT_START = 9'h000,
    parameter logic [8:0] HCNT_END   = 9'h17F,
    parameter logic [8:0] HB_START   = 9'h13F,
    parameter logic [8:0] HB_END     = 9'h17F,
    parameter logic [8:0] HS_START   = 9'h150,
    parameter logic [8:0] HS_END     = HS_START + 9'd27,
    parameter logic [8:0] H_VNEXT    = HB_START,
    parameter logic [8:0] H_VB       = H_VNEXT,
    parameter logic [8:0] H_VS       = HS_START,
    parameter logic [8:0] HINIT      = H_VNEXT,
    parameter logic [8:0] V_START    = 9'h0F8,
    parameter logic [8:0] VCNT_END   = 9'h1FF,
    parameter logic [8:0] VB_START   = 9'h1EF,
    parameter logic [8:0] VB_END     = 9'h10F,
    parameter logic [8:0] VS_START   = 9'h1F0,
    parameter logic [8:0] VS_END     = VS_START + 9'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic [8:0] vrender1,
    output logic [8:0] H,
    output logic       Hinit,
    output logic       Vinit,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS
);

    // Reset contents of the line pipeline: V_START and its two successors.
    localparam logic [8:0] VR_INIT  = (V_START == VCNT_END) ? V_START : V_START + 9'd1;
    localparam logic [8:0] VR1_INIT = (VR_INIT == VCNT_END) ? V_START : VR_INIT + 9'd1;

    // Successor of a line number inside the V_START..VCNT_END range.
    function automatic logic [8:0] vnext(input logic [8:0] v);
        return (v == VCNT_END) ? V_START : v + 9'd1;
    endfunction

    logic [8:0] h_nxt;
    logic [8:0] vd_nxt;
    logic       v_adv;

    // Next-pixel values. Hinit/Vinit are registered from these so that the
    // pulses line up with the pixel whose H/vdump match, not one pixel late.
    always_comb begin
        h_nxt  = (H == HCNT_END) ? HCNT_START : H + 9'd1;
        v_adv  = (H == H_VNEXT);
        vd_nxt = v_adv ? vrender : vdump;
    end

    // Horizontal counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            H <= HCNT_START;
        end else if (pxl_cen) begin
            H <= h_nxt;
        end
    end

    // Line pipeline: all three stages shift together once per line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdump    <= V_START;
            vrender  <= VR_INIT;
            vrender1 <= VR1_INIT;
        end else if (pxl_cen && v_adv) begin
            vdump    <= vrender;
            vrender  <= vrender1;
            vrender1 <= vnext(vrender1);
        end
    end

    // Line and frame start pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Hinit <= 1'b0;
            Vinit <= 1'b0;
        end else if (pxl_cen) begin
            Hinit <= (h_nxt == HINIT);
            Vinit <= (h_nxt == H_VB) && (vd_nxt == VB_END);
        end
    end

    // Horizontal blank and sync. The end compare is tested first so that equal
    // start/end values leave the signal deasserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LHBL <= 1'b0;
            HS   <= 1'b0;
        end else if (pxl_cen) begin
            if (H == HB_END) begin
                LHBL <= 1'b1;
            end else if (H == HB_START) begin
                LHBL <= 1'b0;
            end
            if (H == HS_END) begin
                HS <= 1'b0;
            end else if (H == HS_START) begin
                HS <= 1'b1;
            end
        end
    end

    // Vertical blank and sync. These are sampled once per line at their own H
    // positions and look at the vdump value before any advance on that pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LVBL <= 1'b0;
            VS   <= 1'b0;
        end else if (pxl_cen) begin
            if (H == H_VB) begin
                if (vdump == VB_END) begin
                    LVBL <= 1'b1;
                end else if (vdump == VB_START) begin
                    LVBL <= 1'b0;
                end
            end
            if (H == H_VS) begin
                if (vdump == VS_END) begin
                    VS <= 1'b0;
                end else if (vdump == VS_START) begin
                    VS <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_vtimer.sv
// -----------------------------------------------------------------------------
// tb_jtframe_vtimer
//   Directed bench for jtframe_vtimer.
//   Geometry:
//     - Horizontal timing is the 384-pixel line 020..19F.
//     - The vertical range is shortened to 1E0..1FF (32 lines) so several
//       frame events fit in a short run.
//     - Vertical blank spans the frame wrap: 1F8 -> 1E4.
//   A behavioural line/pixel model predicts every output after each clock.
//   Expectations are queued when a clock is driven and compared once the
//   DUT has clocked. Run-length checks measure pulse widths and periods.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtframe_vtimer;

    // ---------------- geometry under test ----------------
    localparam logic [8:0] P_HSTART = 9'h020;
    localparam logic [8:0] P_HEND   = 9'h19F;
    localparam logic [8:0] P_HBS    = 9'h19F;
    localparam logic [8:0] P_HBE    = 9'h05F;
    localparam logic [8:0] P_HSS    = 9'h033;
    localparam logic [8:0] P_HSE    = 9'h04D;
    localparam logic [8:0] P_VSTART = 9'h1E0;
    localparam logic [8:0] P_VEND   = 9'h1FF;
    localparam logic [8:0] P_VBS    = 9'h1F8;
    localparam logic [8:0] P_VBE    = 9'h1E4;
    localparam logic [8:0] P_VSS    = 9'h1E2;
    localparam logic [8:0] P_VSE    = 9'h1E5;

    // Derived positions: blank start drives line advance, Hinit and LVBL;
    // HS start drives VS.
    localparam logic [8:0] P_VNEXT = 9'h19F;
    localparam logic [8:0] P_VS_H  = 9'h033;

    localparam int LINE_PIX  = 384;
    localparam int FRAME_PIX = 32 * LINE_PIX;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic       pxl_cen;

    logic [8:0] vdump;
    logic [8:0] vrender;
    logic [8:0] vrender1;
    logic [8:0] H;
    logic       Hinit;
    logic       Vinit;
    logic       LHBL;
    logic       LVBL;
    logic       HS;
    logic       VS;

    initial clk = 1'b0;
    always #41.667 clk = ~clk;   // 12 MHz

    jtframe_vtimer #(
        .HCNT_START (P_HSTART),
        .HCNT_END   (P_HEND),
        .HB_START   (P_HBS),
        .HB_END     (P_HBE),
        .HS_START   (P_HSS),
        .HS_END     (P_HSE),
        .V_START    (P_VSTART),
        .VCNT_END   (P_VEND),
        .VB_START   (P_VBS),
        .VB_END     (P_VBE),
        .VS_START   (P_VSS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .vdump    (vdump),
        .vrender  (vrender),
        .vrender1 (vrender1),
        .H        (H),
        .Hinit    (Hinit),
        .Vinit    (Vinit),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .HS       (HS),
        .VS       (VS)
    );

    logic [41:0] dut_vec;
    assign dut_vec = {H, vdump, vrender, vrender1, Hinit, Vinit, LHBL, LVBL, HS, VS};

    // ---------------- scoreboard ----------------
    logic [41:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [41:0] got, input logic [41:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] m_h;
    logic [8:0] m_vd;
    logic       m_lhbl;
    logic       m_lvbl;
    logic       m_hs;
    logic       m_vs;

    function automatic logic [8:0] m_nx(input logic [8:0] v);
        return (v == P_VEND) ? P_VSTART : v + 9'd1;
    endfunction

    task automatic model_reset();
        m_h    = P_HSTART;
        m_vd   = P_VSTART;
        m_lhbl = 1'b0;
        m_lvbl = 1'b0;
        m_hs   = 1'b0;
        m_vs   = 1'b0;
    endtask

    // One pixel of the timing model, evaluated from the values before the pixel.
    task automatic model_pixel();
        if (m_h == P_HBS) m_lhbl = 1'b0;
        if (m_h == P_HBE) m_lhbl = 1'b1;
        if (m_h == P_HSS) m_hs = 1'b1;
        if (m_h == P_HSE) m_hs = 1'b0;
        if (m_h == P_VNEXT) begin
            if (m_vd == P_VBS) m_lvbl = 1'b0;
            if (m_vd == P_VBE) m_lvbl = 1'b1;
        end
        if (m_h == P_VS_H) begin
            if (m_vd == P_VSS) m_vs = 1'b1;
            if (m_vd == P_VSE) m_vs = 1'b0;
        end
        if (m_h == P_VNEXT) m_vd = m_nx(m_vd);
        m_h = (m_h == P_HEND) ? P_HSTART : m_h + 9'd1;
    endtask

    function automatic logic [41:0] model_vec();
        logic hi, vi;
        hi = (m_h == P_VNEXT);
        vi = (m_h == P_VNEXT) && (m_vd == P_VBE);
        return {m_h, m_vd, m_nx(m_vd), m_nx(m_nx(m_vd)), hi, vi, m_lhbl, m_lvbl, m_hs, m_vs};
    endfunction

    // ---------------- run-length / period tracking ----------------
    int   pix;
    int   last_hinit;
    int   last_vinit;
    bit   have_hinit;
    bit   have_vinit;
    int   run_lhbl, run_hs, run_lvbl, run_vs;
    bit   arm_lhbl, arm_hs, arm_lvbl, arm_vs;
    logic prev_lhbl, prev_hs, prev_lvbl, prev_vs;
    int   n_hinit, n_vinit, n_lhbl, n_hs, n_lvbl, n_vs;

    task automatic tracking_reset();
        pix = 0;
        have_hinit = 0;
        have_vinit = 0;
        arm_lhbl = 0;
        arm_hs = 0;
        arm_lvbl = 0;
        arm_vs = 0;
        prev_lhbl = 1'b0;
        prev_hs = 1'b0;
        prev_lvbl = 1'b0;
        prev_vs = 1'b0;
    endtask

    // Measures complete runs of 'active' on a signal. Only runs whose start was
    // seen are checked.
    task automatic track(input string tag, input logic cur, input logic active,
                         inout int run, inout bit arm, inout logic prev,
                         inout int n, input int want);
        if (cur == active) begin
            if (prev != active) begin
                arm = 1;
                run = 1;
            end else if (arm) begin
                run++;
            end
        end else if (prev == active && arm) begin
            check(tag, 42'(run), 42'(want));
            n++;
            arm = 0;
        end
        prev = cur;
    endtask

    task automatic measure();
        pix++;
        if (Hinit) begin
            if (have_hinit) begin
                check("hinit_period", 42'(pix - last_hinit), 42'(LINE_PIX));
                n_hinit++;
            end
            last_hinit = pix;
            have_hinit = 1;
        end
        if (Vinit) begin
            if (have_vinit) begin
                check("vinit_period", 42'(pix - last_vinit), 42'(FRAME_PIX));
                n_vinit++;
            end
            last_vinit = pix;
            have_vinit = 1;
        end
        track("lhbl_low",  LHBL, 1'b0, run_lhbl, arm_lhbl, prev_lhbl, n_lhbl, 64);
        track("hs_high",   HS,   1'b1, run_hs,   arm_hs,   prev_hs,   n_hs,   26);
        track("lvbl_low",  LVBL, 1'b0, run_lvbl, arm_lvbl, prev_lvbl, n_lvbl, 12 * LINE_PIX);
        track("vs_high",   VS,   1'b1, run_vs,   arm_vs,   prev_vs,   n_vs,   3 * LINE_PIX);
    endtask

    // ---------------- driver ----------------
    // One clock with the given enable.
    // - Inputs change on the falling edge.
    // - The model prediction is queued at the same time.
    // - The DUT is sampled 1 ns after the rising edge.
    task automatic step(input logic cen);
        logic [41:0] e;
        @(negedge clk);
        pxl_cen = cen;
        if (cen) model_pixel();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 42'd1, 42'd0);
        end else begin
            e = exp_q.pop_front();
            check(cen ? "pixel" : "hold", dut_vec, e);
        end
        if (cen) measure();
    endtask

    localparam logic [41:0] RESET_VEC = {P_HSTART, P_VSTART, 9'h1E1, 9'h1E2, 6'b000000};

    initial begin
        n_hinit = 0;
        n_vinit = 0;
        n_lhbl = 0;
        n_hs = 0;
        n_lvbl = 0;
        n_vs = 0;
        last_hinit = 0;
        last_vinit = 0;
        run_lhbl = 0;
        run_hs = 0;
        run_lvbl = 0;
        run_vs = 0;
        rst = 1'b1;
        pxl_cen = 1'b0;
        model_reset();
        tracking_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec, RESET_VEC);
        @(negedge clk);
        rst = 1'b0;

        // Enable low after reset: nothing moves
        for (int i = 0; i < 4; i++) step(1'b0);

        // Long run: pixel enable every other clock, with random extra idle clocks
        for (int i = 0; i < 16000; i++) begin
            step(1'b1);
            step(1'b0);
            if ($urandom_range(0, 15) == 0) step(1'b0);
        end

        // Every measured event must have happened at least once
        check("hinit_seen", 42'(n_hinit > 30), 42'd1);
        check("vinit_seen", 42'(n_vinit >= 1), 42'd1);
        check("lhbl_seen",  42'(n_lhbl > 30),  42'd1);
        check("hs_seen",    42'(n_hs > 30),    42'd1);
        check("lvbl_seen",  42'(n_lvbl >= 1), 42'd1);
        check("vs_seen",    42'(n_vs >= 1),   42'd1);

        // Mid-frame asynchronous reset, asserted between clock edges
        @(negedge clk);
        pxl_cen = 1'b0;
        #5;
        rst = 1'b1;
        #1;
        check("async_reset", dut_vec, RESET_VEC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tracking_reset();
        exp_q.delete();

        // Frozen until the first enable, then a fresh frame starts
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1);
            step(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
